row_scheduler: RTL
==================

ROW_SCHEDULER -- requirements
Module: row_scheduler

Interface
REQ-001 Parameter ROWS, default 8, number of multiplexed LED rows (power of 2, 2..16).
REQ-002 Parameter GS_PERIOD, default 4096, GSCLK strobes per row display period (power of 2, >=16).
REQ-003 clock  in  1  single system clock, all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous assert, active-low reset.
REQ-005 enable  in  1  level; 1 = run scan, 0 = stop at next row boundary.
REQ-006 dc_reload  in  1  one-cycle pulse; request dot-correction reload at next row boundary.
REQ-007 shift_done  in  1  one-cycle pulse from serial shifter: last bit of current load sent.
REQ-008 shift_start  out  1  one-cycle pulse commanding shifter to begin a load.
REQ-009 shift_row  out  clog2(ROWS)  row index whose grayscale data the shifter loads; stable from shift_start to shift_done.
REQ-010 led_mode  out  1  1 = dot-correction load, 0 = grayscale; also drives shifter data select.
REQ-011 led_xlat  out  1  one-cycle latch pulse to TLC5941 chain.
REQ-012 led_blank  out  1  1 = outputs off, GSCLK counter cleared in driver.
REQ-013 led_gsclk  out  1  grayscale clock, clock/8, 50% duty.
REQ-014 row_sel  out  ROWS  one-hot active-high row enable; all-zero when no row displayed.
REQ-015 frame_start  out  1  one-cycle pulse when row 0 becomes displayed.
REQ-016 overrun  out  1  sticky; shifter missed a row deadline.

Function
REQ-017 led_gsclk SHALL be bit 2 of a free-running 3-bit counter; gs_strobe SHALL be counter==0.
REQ-018 States: IDLE, DC_SHIFT, DC_LATCH, PREFILL, SWAP, DISPLAY, STALL, DRAIN.
REQ-019 IDLE: blank=1, mode=1, row_sel=0; enable=1 -> DC_SHIFT with shift_start pulse.
REQ-020 DC_SHIFT: mode=1, blank=1; shift_done -> DC_LATCH.
REQ-021 DC_LATCH: xlat=1 one cycle, mode<=0, load_row<=0 -> PREFILL with shift_start.
REQ-022 PREFILL: blank=1; shift_done -> SWAP.
REQ-023 SWAP (one cycle): blank=1, xlat=1, row_sel<=onehot(load_row), load_row<=load_row+1 mod ROWS, gs_count<=0, shift_start pulse for new load_row, ready<=0; frame_start=1 when row displayed is 0; -> DISPLAY.
REQ-024 DISPLAY: blank=0; gs_count increments on gs_strobe; shift_done sets ready.
REQ-025 At gs_strobe with gs_count==GS_PERIOD-1: if enable=0 or dc_reload pending -> DRAIN; else if ready (including shift_done same cycle) -> SWAP; else -> STALL, overrun<=1.
REQ-026 STALL: blank=1, row_sel held; shift_done -> SWAP.
REQ-027 DRAIN: blank=1, row_sel=0; wait outstanding shift_done (or none) then -> DC_SHIFT with shift_start and mode=1 if reload pending and enable=1, else IDLE.
REQ-028 dc_reload SHALL set a pending flag in any state, cleared on entry to DC_SHIFT; reload pulse in IDLE taken when enable rises.
REQ-029 shift_done in DISPLAY/IDLE with no load outstanding SHALL be ignored.
REQ-030 shift_row SHALL equal load_row; led_xlat SHALL never assert while a load is outstanding.
REQ-031 Row order strictly 0,1,...,ROWS-1,0; gs_count wraps only through SWAP/STALL/DRAIN.

Reset
REQ-032 reset_n low: state=IDLE, led_mode=1, led_blank=1, led_xlat=0, shift_start=0, row_sel=0, load_row=0, gs_count=0, gsclk counter=0, frame_start=0, overrun=0, pending=0, ready=0; reset mid-shift abandons load, no xlat.

Structure
REQ-033 Package pixel_pkg SHALL hold state enum, GSCLK_DIV=8, GS_BITS=576, DC_BITS=288.
REQ-034 One sub-module gsclk_gen: 3-bit divider producing led_gsclk and gs_strobe.

Verification (GS_PERIOD=16, ROWS=4, shifter model done N clocks after start)
REQ-035 Reset, enable=1, N=10 -> DC load, xlat, prefill row 0, SWAP: row_sel=0001, frame_start=1, blank low 128 clocks.
REQ-036 N=20, run 9 rows -> row_sel 0001,0010,0100,1000,0001...; xlat once per swap; overrun=0.
REQ-037 N=200 -> STALL after first display, overrun=1, blank=1 until done, then next row shown.
REQ-038 dc_reload mid-row 2 -> after row 2 ends: row_sel=0, mode=1, DC load, then rows restart at 0.
REQ-039 enable=0 mid-row; shift_done coincident with gs wrap -> row finishes, IDLE, blank=1; coincident done treated ready.
REQ-040 reset_n low during DC_SHIFT -> all outputs reset values next edge, no xlat pulse.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared constants and scan-state encoding for the TLC5941 row-multiplexed LED driver.
package pixel_pkg;

  localparam int GSCLK_DIV = 8;
  localparam int GS_BITS   = 576;
  localparam int DC_BITS   = 288;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DC_SHIFT,
    ST_DC_LATCH,
    ST_PREFILL,
    ST_SWAP,
    ST_DISPLAY,
    ST_STALL,
    ST_DRAIN
  } sched_state_t;

endpackage

// File: rtl/gsclk_gen.sv
// Free-running divider: led_gsclk is the divider MSB, gs_strobe marks each divider wrap.
module gsclk_gen
  import pixel_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  output logic led_gsclk,
  output logic gs_strobe
);

  localparam int DW = $clog2(GSCLK_DIV);

  logic [DW-1:0] div_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) div_count <= '0;
    else          div_count <= div_count + DW'(1);
  end

  assign led_gsclk = div_count[DW-1];
  assign gs_strobe = (div_count == '0);

endmodule

// File: rtl/row_scheduler.sv
// Row scan sequencer: overlaps the shift of the next row's grayscale data with the display
// of the current row, and performs dot-correction loads at row boundaries.
module row_scheduler
  import pixel_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int GS_PERIOD = 4096
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    dc_reload,
  input  logic                    shift_done,
  output logic                    shift_start,
  output logic [$clog2(ROWS)-1:0] shift_row,
  output logic                    led_mode,
  output logic                    led_xlat,
  output logic                    led_blank,
  output logic                    led_gsclk,
  output logic [ROWS-1:0]         row_sel,
  output logic                    frame_start,
  output logic                    overrun
);

  localparam int RW = $clog2(ROWS);
  localparam int GW = $clog2(GS_PERIOD);
  localparam logic [GW-1:0] GS_LAST = GW'(GS_PERIOD - 1);

  sched_state_t  state;
  logic [RW-1:0] load_row;
  logic [GW-1:0] gs_count;
  logic          pending;
  logic          ready;
  logic          outstanding;
  logic          gs_strobe;
  logic          done_valid;

  gsclk_gen u_gsclk_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .led_gsclk (led_gsclk),
    .gs_strobe (gs_strobe)
  );

  // A done pulse only counts when a load is actually in flight.
  assign done_valid = shift_done && outstanding;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      load_row    <= '0;
      row_sel     <= '0;
      gs_count    <= '0;
      pending     <= 1'b0;
      ready       <= 1'b0;
      outstanding <= 1'b0;
      shift_start <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      shift_start <= 1'b0;
      frame_start <= 1'b0;
      if (dc_reload) pending <= 1'b1;
      if (done_valid) outstanding <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state       <= ST_DC_SHIFT;
            shift_start <= 1'b1;
            outstanding <= 1'b1;
            pending     <= 1'b0;
          end
        end
        ST_DC_SHIFT: begin
          if (done_valid) state <= ST_DC_LATCH;
        end
        ST_DC_LATCH: begin
          load_row    <= '0;
          state       <= ST_PREFILL;
          shift_start <= 1'b1;
          outstanding <= 1'b1;
        end
        ST_PREFILL: begin
          if (done_valid) state <= ST_SWAP;
        end
        ST_SWAP: begin
          row_sel     <= ROWS'(1) << load_row;
          load_row    <= load_row + RW'(1);
          gs_count    <= '0;
          shift_start <= 1'b1;
          outstanding <= 1'b1;
          ready       <= 1'b0;
          frame_start <= (load_row == '0);
          state       <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (done_valid) ready <= 1'b1;
          // Row boundary: a done arriving on the final strobe still counts as ready.
          if (gs_strobe) begin
            if (gs_count == GS_LAST) begin
              gs_count <= '0;
              if (!enable || pending) begin
                state   <= ST_DRAIN;
                row_sel <= '0;
              end else if (ready || done_valid) begin
                state <= ST_SWAP;
              end else begin
                state   <= ST_STALL;
                overrun <= 1'b1;
              end
            end else begin
              gs_count <= gs_count + GW'(1);
            end
          end
        end
        ST_STALL: begin
          if (done_valid) state <= ST_SWAP;
        end
        ST_DRAIN: begin
          if (!outstanding || done_valid) begin
            if (pending && enable) begin
              state       <= ST_DC_SHIFT;
              shift_start <= 1'b1;
              outstanding <= 1'b1;
              pending     <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The latch pulse in DC_LATCH still sees mode high, so the chain captures dot-correction data.
  assign led_xlat  = (state == ST_DC_LATCH) || (state == ST_SWAP);
  assign led_blank = (state != ST_DISPLAY);
  assign led_mode  = (state == ST_IDLE) || (state == ST_DC_SHIFT) || (state == ST_DC_LATCH);
  assign shift_row = load_row;

endmodule
